// File: rtl/ipf_res_packer_if.sv
// ipf_res_packer_if: result-capture inputs and addressed beat stream of the IPF result packer
interface ipf_res_packer_if #(
  parameter int VEC_W  = 1152,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 16
);
  logic              res_valid;
  logic [VEC_W-1:0]  result;
  logic              finish;
  logic              o_valid;
  logic              o_ready;
  logic [BUS_W-1:0]  o_data;
  logic [ADDR_W-1:0] o_addr;
  logic              o_last;
  logic              overflow;
  logic              done;
  modport master (
    input  res_valid, result, finish, o_ready,
    output o_valid, o_data, o_addr, o_last, overflow, done
  );
  modport slave (
    output res_valid, result, finish, o_ready,
    input  o_valid, o_data, o_addr, o_last, overflow, done
  );
endinterface

// File: rtl/ipf_res_packer.sv
// ipf_res_packer: buffers IPF result vectors and serializes them into addressed BUS_W beats
module ipf_res_packer #(
  parameter int OUT_W  = 9,
  parameter int LANES  = 128,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2
) (
  input logic clk,
  input logic rst,
  ipf_res_packer_if.master bus
);
  localparam int VEC_W = LANES * OUT_W;
  localparam int BEATS = VEC_W / BUS_W;
  localparam int BW = $clog2(BEATS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state, state_nx;
  logic [VEC_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] beat;
  logic fin_seen, hs, pop, push;
  assign hs = bus.o_valid & bus.o_ready;
  assign pop = hs & bus.o_last;
  // a full FIFO still accepts when the head is released on the same edge
  assign push = bus.res_valid & (state != DONE) & ((count != FULL_CNT) | pop);
  assign bus.o_valid = state == SEND;
  assign bus.o_last = bus.o_valid & (beat == LAST_BEAT);
  assign bus.o_data = bus.o_valid ? mem[rd_ptr][beat*BUS_W +: BUS_W] : '0;
  assign bus.done = state == DONE;
  // a vector arriving while idle after finish is drained before completing
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = (count != '0) ? SEND : (fin_seen && !push) ? DONE : IDLE;
    else if (state == SEND && pop && count == CW'(1) && !push) state_nx = IDLE;
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= bus.result;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      beat <= '0;
      fin_seen <= 1'b0;
      bus.o_addr <= '0;
      bus.overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (hs) begin
        beat <= bus.o_last ? '0 : beat + 1'b1;
        bus.o_addr <= bus.o_addr + 1'b1;
      end
      if (bus.res_valid && !push) bus.overflow <= 1'b1;
      if (bus.finish) fin_seen <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ipf_res_packer.sv
// tb_ipf_res_packer: randomized and directed bench with a queue-based reference model and scoreboard
module tb_ipf_res_packer;
  localparam int OUT_W = 9, LANES = 128, BUS_W = 64, DEPTH = 2;
  localparam int VEC_W = LANES * OUT_W, BEATS = VEC_W / BUS_W;
  typedef struct {logic [BUS_W-1:0] d; logic l;} beat_t;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  ipf_res_packer_if #(.VEC_W(VEC_W), .BUS_W(BUS_W), .ADDR_W(16)) bus();
  ipf_res_packer_if #(.VEC_W(VEC_W), .BUS_W(BUS_W), .ADDR_W(5)) bus5();
  ipf_res_packer #(.OUT_W(OUT_W), .LANES(LANES), .BUS_W(BUS_W), .ADDR_W(16), .DEPTH(DEPTH))
    dut (.clk(clk), .rst(rst), .bus(bus));
  ipf_res_packer #(.OUT_W(OUT_W), .LANES(LANES), .BUS_W(BUS_W), .ADDR_W(5), .DEPTH(DEPTH))
    dut5 (.clk(clk), .rst(rst), .bus(bus5));
  assign bus5.res_valid = bus.res_valid;
  assign bus5.result = bus.result;
  assign bus5.finish = bus.finish;
  assign bus5.o_ready = bus.o_ready;
  beat_t exp_q[$];
  beat_t b;
  int checks = 0, errors = 0, vecs = 0, v0 = 0, exp_addr = 0, beats_seen = 0;
  logic fin_m = 0, done_m = 0, ovf_m = 0, pv = 0, push_n;
  logic [BUS_W-1:0] pd;
  logic [15:0] pa;
  logic [VEC_W-1:0] ramp, v;
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction
  // reference model + monitor: predicts each edge from stable values at the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      vecs = 0; exp_addr = 0; fin_m = 0; done_m = 0; ovf_m = 0; pv = 0;
    end else begin
      chk("done", bus.done, done_m);
      chk("overflow", bus.overflow, ovf_m);
      chk("done5", bus5.done, done_m);
      if (pv) begin
        chk("hold_valid", bus.o_valid, 1);
        chk("hold_data", bus.o_data, pd);
        chk("hold_addr", bus.o_addr, pa);
      end
      v0 = vecs;
      if (bus.o_valid && exp_q.size() == 0) chk("spurious_valid", bus.o_valid, 0);
      else if (bus.o_valid && bus.o_ready) begin
        b = exp_q.pop_front();
        chk("data", bus.o_data, b.d);
        chk("last", bus.o_last, b.l);
        chk("addr", bus.o_addr, 64'(exp_addr % 65536));
        chk("valid5", bus5.o_valid, 1);
        chk("data5", bus5.o_data, b.d);
        chk("addr5", bus5.o_addr, 64'(exp_addr % 32));
        exp_addr++;
        beats_seen++;
        if (b.l) vecs--;
      end
      pv = bus.o_valid && !bus.o_ready;
      pd = bus.o_data;
      pa = bus.o_addr;
      push_n = bus.res_valid && !done_m && vecs < DEPTH;
      if (push_n) begin
        vecs++;
        for (int k = 0; k < BEATS; k++) exp_q.push_back('{bus.result[k*BUS_W +: BUS_W], k == BEATS - 1});
      end else if (bus.res_valid) ovf_m = 1;
      if (fin_m && v0 == 0 && !push_n) done_m = 1;
      if (bus.finish) fin_m = 1;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_vec(input logic [VEC_W-1:0] vec, input logic fin);
    bus.res_valid = 1'b1;
    bus.result = vec;
    bus.finish = fin;
    tick();
    bus.res_valid = 1'b0;
    bus.finish = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_addr", bus.o_addr, 0);
    chk("rst_last", bus.o_last, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_done", bus.done, 0);
  endtask
  task automatic wait_drain(input int n);
    int i = 0;
    while ((exp_q.size() != 0 || bus.o_valid) && i < n) begin
      tick();
      i++;
    end
    chk("drained", 64'(exp_q.size()), 0);
  endtask
  task automatic rand_vec(output logic [VEC_W-1:0] r);
    for (int w = 0; w < VEC_W / 32; w++) r[w*32 +: 32] = $urandom();
  endtask
  initial begin
    int b0, i;
    bus.res_valid = 1'b0;
    bus.result = '0;
    bus.finish = 1'b0;
    bus.o_ready = 1'b0;
    for (int l = 0; l < LANES; l++) ramp[l*OUT_W +: OUT_W] = OUT_W'(l % 512);
    tick();
    do_reset();
    // single ramp vector: one-cycle latency then 18 consecutive beats
    bus.o_ready = 1'b1;
    send_vec(ramp, 1'b0);
    chk("lat_n", bus.o_valid, 0);
    tick();
    chk("lat_n1_valid", bus.o_valid, 1);
    chk("lat_n1_data", bus.o_data, ramp[63:0]);
    b0 = beats_seen;
    repeat (BEATS) tick();
    chk("burst_beats", 64'(beats_seen - b0), BEATS);
    chk("burst_idle", bus.o_valid, 0);
    // same vector with a toggling sink
    do_reset();
    send_vec(ramp, 1'b0);
    b0 = beats_seen;
    repeat (40) begin
      bus.o_ready = ~bus.o_ready;
      tick();
    end
    chk("toggle_beats", 64'(beats_seen - b0), BEATS);
    // three vectors into a stalled sink: third is dropped
    do_reset();
    bus.o_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      rand_vec(v);
      send_vec(v, 1'b0);
    end
    tick();
    chk("stall_overflow", bus.overflow, 1);
    chk("stall_queued", 64'(exp_q.size()), 2 * BEATS);
    bus.o_ready = 1'b1;
    wait_drain(200);
    chk("stall_addr_end", 64'(exp_addr), 2 * BEATS);
    // two back-to-back vectors with finish on the second
    do_reset();
    rand_vec(v);
    send_vec(v, 1'b0);
    rand_vec(v);
    send_vec(v, 1'b1);
    wait_drain(200);
    tick();
    chk("fin_done", bus.done, 1);
    chk("fin_overflow", bus.overflow, 0);
    send_vec(v, 1'b0);
    tick();
    chk("done_ignores", bus.overflow, 1);
    // reset in the middle of a vector clears everything
    do_reset();
    bus.o_ready = 1'b0;
    for (int n = 0; n < 3; n++) send_vec(ramp, 1'b0);
    bus.o_ready = 1'b1;
    b0 = beats_seen;
    i = 0;
    while (beats_seen - b0 < 7 && i < 100) begin
      tick();
      i++;
    end
    chk("beat7_reached", 64'(beats_seen - b0), 7);
    do_reset();
    rand_vec(v);
    send_vec(v, 1'b0);
    wait_drain(200);
    chk("post_rst_addr", 64'(exp_addr), BEATS);
    // randomized traffic, finish near the end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.res_valid = ($urandom_range(0, 3) == 0);
      rand_vec(v);
      bus.result = v;
      bus.o_ready = ($urandom_range(0, 2) != 0);
      bus.finish = (c == 2900);
      tick();
    end
    bus.res_valid = 1'b0;
    bus.finish = 1'b0;
    bus.o_ready = 1'b1;
    wait_drain(200);
    i = 0;
    while (!bus.done && i < 10) begin
      tick();
      i++;
    end
    chk("rand_done", bus.done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
